// File: rtl/fp_round_pipe_if.sv
// Handshake and data bundle for the FP rounding pipe.
// master drives operands and out_ready; slave is the rounder.
interface fp_round_pipe_if #(
  parameter int MANT_W = 23,
  parameter int EXP_W  = 8
);
  logic              in_valid;
  logic              in_ready;
  logic              in_sign;
  logic [EXP_W-1:0]  in_exp;
  logic [MANT_W-1:0] in_mant;
  logic [2:0]        in_rm;
  logic              out_valid;
  logic              out_ready;
  logic              out_sign;
  logic [EXP_W-1:0]  out_exp;
  logic [MANT_W-1:0] out_mant;
  logic              out_inexact;
  logic              out_overflow;
  logic              out_bad_rm;

  modport master (
    output in_valid, in_sign, in_exp, in_mant, in_rm, out_ready,
    input  in_ready, out_valid, out_sign, out_exp, out_mant,
    input  out_inexact, out_overflow, out_bad_rm
  );

  modport slave (
    input  in_valid, in_sign, in_exp, in_mant, in_rm, out_ready,
    output in_ready, out_valid, out_sign, out_exp, out_mant,
    output out_inexact, out_overflow, out_bad_rm
  );
endinterface

// File: rtl/fp_round_pipe.sv
// Two-stage IEEE 754 mantissa rounder, all RISC-V rounding modes.
// S1 decodes the round-up decision, S2 adds and registers the result.
module fp_round_pipe #(
  parameter int MANT_W = 23,
  parameter int DROP_W = 4,
  parameter int EXP_W  = 8
) (
  input logic             clk,
  input logic             reset,
  fp_round_pipe_if.slave  bus
);
  localparam int KEEP_W = MANT_W - DROP_W;

  logic              s1_valid;
  logic              s1_sign;
  logic [EXP_W-1:0]  s1_exp;
  logic [MANT_W-1:0] s1_mant;
  logic              s1_inc;
  logic              s1_inexact;
  logic              s1_bad_rm;
  logic              s1_special;

  logic s2_adv;

  assign s2_adv      = ~bus.out_valid | bus.out_ready;
  assign bus.in_ready = ~s1_valid | s2_adv;

  logic lsb, grd, stk, special, bad_rm, inc_d;

  always_comb begin
    lsb     = bus.in_mant[DROP_W];
    grd     = bus.in_mant[DROP_W-1];
    stk     = |bus.in_mant[DROP_W-2:0];
    special = &bus.in_exp;
    bad_rm  = bus.in_rm > 3'd4;
    inc_d   = 1'b0;
    unique case (1'b1)
      (bus.in_rm == 3'b001): inc_d = 1'b0;
      (bus.in_rm == 3'b010): inc_d = bus.in_sign & (grd | stk);
      (bus.in_rm == 3'b011): inc_d = ~bus.in_sign & (grd | stk);
      (bus.in_rm == 3'b100): inc_d = grd;
      default:               inc_d = grd & (lsb | stk);
    endcase
    if (special) inc_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid   <= 1'b0;
      s1_sign    <= 1'b0;
      s1_exp     <= '0;
      s1_mant    <= '0;
      s1_inc     <= 1'b0;
      s1_inexact <= 1'b0;
      s1_bad_rm  <= 1'b0;
      s1_special <= 1'b0;
    end else if (bus.in_ready) begin
      s1_valid <= bus.in_valid;
      if (bus.in_valid) begin
        s1_sign    <= bus.in_sign;
        s1_exp     <= bus.in_exp;
        s1_mant    <= bus.in_mant;
        s1_inc     <= inc_d;
        s1_inexact <= ~special & (grd | stk);
        s1_bad_rm  <= bad_rm;
        s1_special <= special;
      end
    end
  end

  logic [KEEP_W:0]   kept;
  logic [EXP_W-1:0]  exp_inc;
  logic [MANT_W-1:0] mant_d;
  logic [EXP_W-1:0]  exp_d;
  logic              ovf_d;
  logic              inexact_d;

  // Carry out of the kept field renormalises to 1.0 x 2^(e+1).
  always_comb begin
    kept      = {1'b0, s1_mant[MANT_W-1:DROP_W]} + {{KEEP_W{1'b0}}, s1_inc};
    exp_inc   = s1_exp + EXP_W'(1);
    mant_d    = {kept[KEEP_W-1:0], {DROP_W{1'b0}}};
    exp_d     = s1_exp;
    ovf_d     = 1'b0;
    inexact_d = s1_inexact;
    if (s1_special) begin
      mant_d = s1_mant;
    end else if (kept[KEEP_W]) begin
      mant_d    = '0;
      exp_d     = exp_inc;
      ovf_d     = &exp_inc;
      inexact_d = s1_inexact | ovf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      bus.out_valid    <= 1'b0;
      bus.out_sign     <= 1'b0;
      bus.out_exp      <= '0;
      bus.out_mant     <= '0;
      bus.out_inexact  <= 1'b0;
      bus.out_overflow <= 1'b0;
      bus.out_bad_rm   <= 1'b0;
    end else if (s2_adv) begin
      bus.out_valid <= s1_valid;
      if (s1_valid) begin
        bus.out_sign     <= s1_sign;
        bus.out_exp      <= exp_d;
        bus.out_mant     <= mant_d;
        bus.out_inexact  <= inexact_d;
        bus.out_overflow <= ovf_d;
        bus.out_bad_rm   <= s1_bad_rm;
      end
    end
  end
endmodule

// File: tb/tb_fp_round_pipe.sv
// Randomised and directed bench for fp_round_pipe.
// Results are scored against an arithmetic rounding model.
module tb_fp_round_pipe;
  localparam int MW = 23;
  localparam int DW = 4;
  localparam int EW = 8;
  localparam int KW = MW - DW;

  typedef logic [34:0] res_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  fp_round_pipe_if #(.MANT_W(MW), .EXP_W(EW)) bus ();

  fp_round_pipe #(.MANT_W(MW), .DROP_W(DW), .EXP_W(EW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, want);
    end
  endtask

  function automatic res_t model(input logic sign, input logic [7:0] e,
                                 input logic [22:0] m, input logic [2:0] rm);
    int unsigned trunc, rem, kept, ne;
    logic up, bad, ovf;
    bad = (rm > 3'd4);
    if (e == 8'hFF) return {sign, e, m, 1'b0, 1'b0, bad};
    trunc = int'(m) / 16;
    rem   = int'(m) % 16;
    case (bad ? 3'd0 : rm)
      3'd1:    up = 1'b0;
      3'd2:    up = sign && rem != 0;
      3'd3:    up = !sign && rem != 0;
      3'd4:    up = rem >= 8;
      default: up = rem > 8 || (rem == 8 && trunc % 2 == 1);
    endcase
    kept = trunc + (up ? 1 : 0);
    ovf  = 1'b0;
    ne   = int'(e);
    if (kept == (1 << KW)) begin
      ne   = ne + 1;
      kept = 0;
      ovf  = (ne == 255);
    end
    return {sign, 8'(ne), 23'(kept * 16), rem != 0, ovf, bad};
  endfunction

  function automatic res_t dut_out();
    return {bus.out_sign, bus.out_exp, bus.out_mant,
            bus.out_inexact, bus.out_overflow, bus.out_bad_rm};
  endfunction

  res_t exp_q[$];
  res_t held;
  res_t pop_val;
  logic stall_prev = 1'b0;
  logic popped;
  logic fired;

  task automatic step();
    @(negedge clk);
    popped = 1'b0;
    fired  = 1'b0;
    if (stall_prev) check("hold", dut_out(), held);
    if (bus.out_valid && bus.out_ready) begin
      popped  = 1'b1;
      pop_val = dut_out();
      if (exp_q.size() == 0) check("spurious", 1, 0);
      else check("result", pop_val, exp_q.pop_front());
    end
    if (bus.in_valid && bus.in_ready) begin
      fired = 1'b1;
      exp_q.push_back(model(bus.in_sign, bus.in_exp, bus.in_mant, bus.in_rm));
    end
    stall_prev = bus.out_valid && !bus.out_ready;
    held = dut_out();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input logic s, input logic [7:0] e,
                        input logic [22:0] m, input logic [2:0] rm);
    bus.in_sign = s;
    bus.in_exp  = e;
    bus.in_mant = m;
    bus.in_rm   = rm;
  endtask

  task automatic directed(input string tag, input logic s, input logic [7:0] e,
                          input logic [22:0] m, input logic [2:0] rm,
                          input logic [7:0] we, input logic [22:0] wm,
                          input logic wi, input logic wo, input logic wb);
    int lat;
    set_op(s, e, m, rm);
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    step();
    bus.in_valid = 1'b0;
    lat = 0;
    do begin
      step();
      lat++;
    end while (!popped && lat < 8);
    check({tag, "_lat"}, lat, 2);
    check(tag, pop_val, {s, we, wm, wi, wo, wb});
  endtask

  task automatic rand_op();
    logic [7:0]  e;
    logic [22:0] m;
    case ($urandom_range(0, 3))
      0:       e = 8'hFE;
      1:       e = 8'hFF;
      2:       e = 8'h00;
      default: e = 8'($urandom);
    endcase
    case ($urandom_range(0, 3))
      0:       m = {19'h7FFFF, 4'($urandom)};
      1:       m = 23'($urandom_range(0, 31));
      default: m = 23'($urandom);
    endcase
    set_op(1'($urandom), e, m, 3'($urandom));
  endtask

  logic [22:0] bp_mant [5];

  initial begin
    int acc, npop, first, last, n;
    reset = 1'b1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    set_op(1'b0, 8'h00, 23'h0, 3'd0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_in_ready", bus.in_ready, 1);
    check("rst_out_data", dut_out(), 0);
    @(posedge clk);
    #1;

    directed("rne_tie_even", 0, 8'h80, 23'h000008, 3'd0, 8'h80, 23'h000000, 1, 0, 0);
    directed("rne_tie_odd",  0, 8'h80, 23'h000018, 3'd0, 8'h80, 23'h000020, 1, 0, 0);
    directed("rne_below",    0, 8'h80, 23'h000007, 3'd0, 8'h80, 23'h000000, 1, 0, 0);
    directed("carry",        0, 8'h80, 23'h7FFFFF, 3'd0, 8'h81, 23'h000000, 1, 0, 0);
    directed("ovf_rup",      0, 8'hFE, 23'h7FFFF9, 3'd3, 8'hFF, 23'h000000, 1, 1, 0);
    directed("ovf_rtz",      0, 8'hFE, 23'h7FFFF9, 3'd1, 8'hFE, 23'h7FFFF0, 1, 0, 0);
    directed("rdn_neg",      1, 8'h80, 23'h000001, 3'd2, 8'h80, 23'h000010, 1, 0, 0);
    directed("rdn_pos",      0, 8'h80, 23'h000001, 3'd2, 8'h80, 23'h000000, 1, 0, 0);
    directed("rmm",          0, 8'h80, 23'h000008, 3'd4, 8'h80, 23'h000010, 1, 0, 0);
    directed("bad_rm",       0, 8'h80, 23'h000018, 3'd6, 8'h80, 23'h000020, 1, 0, 1);
    directed("special",      0, 8'hFF, 23'h000005, 3'd3, 8'hFF, 23'h000005, 0, 0, 0);
    directed("denorm_carry", 0, 8'h00, 23'h7FFFF8, 3'd0, 8'h01, 23'h000000, 1, 0, 0);

    for (int i = 0; i < 5; i++) bp_mant[i] = 23'((i + 1) * 16 + 9);
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    acc = 0;
    for (int k = 0; k < 4; k++) begin
      set_op(0, 8'h40, bp_mant[acc], 3'd0);
      step();
      if (fired) acc++;
    end
    check("bp_accepted", acc, 2);
    check("bp_in_ready", bus.in_ready, 0);
    bus.out_ready = 1'b1;
    npop = 0;
    first = -1;
    last = -1;
    for (int k = 0; k < 20; k++) begin
      bus.in_valid = (acc < 5);
      if (acc < 5) set_op(0, 8'h40, bp_mant[acc], 3'd0);
      step();
      if (fired) acc++;
      if (popped) begin
        npop++;
        if (first < 0) first = k;
        last = k;
      end
    end
    check("bp_pops", npop, 5);
    check("bp_span", last - first, 4);

    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    acc = 0;
    for (int k = 0; k < 3; k++) begin
      set_op(1, 8'h22, 23'h012345, 3'd4);
      step();
      if (fired) acc++;
    end
    check("rst_fill", acc, 2);
    bus.in_valid = 1'b0;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    exp_q.delete();
    stall_prev = 1'b0;
    check("mid_rst_out_valid", bus.out_valid, 0);
    check("mid_rst_in_ready", bus.in_ready, 1);
    check("mid_rst_out_mant", bus.out_mant, 0);
    directed("post_rst", 1, 8'h10, 23'h000019, 3'd0, 8'h10, 23'h000020, 1, 0, 0);

    rand_op();
    for (int k = 0; k < 3000; k++) begin
      bus.in_valid  = ($urandom_range(0, 3) != 0);
      bus.out_ready = ($urandom_range(0, 9) < 7);
      step();
      if (fired) rand_op();
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    n = 0;
    while (exp_q.size() != 0 && n < 20) begin
      step();
      n++;
    end
    check("drain_empty", exp_q.size(), 0);
    check("drain_out_valid", bus.out_valid, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
